// File: rtl/cpu_step_controller.sv
// CPU run/step/breakpoint controller for a board-level debug harness.
// Debounces the two push-buttons and gates the CPU clock enable.
module cpu_step_controller #(
   parameter int DB_COUNT = 50000,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_step,
   input  logic                btn_run,
   input  logic                single_mode,
   input  logic [7:0]          burst_len,
   input  logic                bp_en,
   input  logic [PC_WIDTH-1:0] bp_addr,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                cpu_en,
   output logic                halted,
   output logic                bp_hit,
   output logic [1:0]          state,
   output logic [15:0]         instr_cnt
);

   typedef enum logic [1:0] {
      HALT = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10,
      BP   = 2'b11
   } state_e;

   localparam int CW = $clog2(DB_COUNT + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_COUNT - 1);

   // Bit 0 is the step button, bit 1 the run button.
   logic [1:0]         raw_btn;
   logic [1:0]         s1_q;
   logic [1:0]         s2_q;
   logic [1:0]         lvl_q;
   logic [1:0]         prv_q;
   logic [1:0]         arm_q;
   logic [1:0][CW-1:0] cnt_q;
   logic [1:0][CW-1:0] rel_q;
   logic [1:0]         press;
   logic               step_press;
   logic               run_press;

   state_e      state_q;
   state_e      state_d;
   logic [7:0]  rem_q;
   logic [7:0]  rem_d;
   logic        skip_q;
   logic        skip_d;
   logic [15:0] icnt_q;
   logic        match;
   logic        eff_match;
   logic        busy;
   logic [7:0]  burst_ld;

   assign raw_btn    = {btn_run, btn_step};
   // A button is armed only after it has been seen released for a full
   // debounce window, so one held through reset cannot fire on release.
   assign press      = lvl_q & ~prv_q & arm_q;
   assign step_press = press[0];
   assign run_press  = press[1];

   // Synchronize, debounce and arm both buttons.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         lvl_q <= '0;
         prv_q <= '0;
         arm_q <= '0;
         cnt_q <= '0;
         rel_q <= '0;
      end else begin
         s1_q  <= raw_btn;
         s2_q  <= s1_q;
         prv_q <= lvl_q;
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != lvl_q[i]) begin
               if (cnt_q[i] == DB_LAST) begin
                  lvl_q[i] <= s2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
            if (s2_q[i]) begin
               rel_q[i] <= '0;
            end else if (rel_q[i] != DB_LAST) begin
               rel_q[i] <= rel_q[i] + 1'b1;
            end else begin
               arm_q[i] <= 1'b1;
            end
         end
      end
   end

   assign match     = bp_en & (pc == bp_addr);
   assign eff_match = match & ~skip_q;
   assign busy      = (state_q == RUN) | (state_q == STEP);
   assign cpu_en    = busy & ~eff_match;
   assign burst_ld  = (burst_len == 8'd0) ? 8'd1 : burst_len;

   // Next-state logic; skip lets the instruction parked on the
   // breakpoint execute once after resuming.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      skip_d  = busy ? 1'b0 : skip_q;
      unique case (state_q)
         HALT: begin
            if (!single_mode && run_press) begin
               state_d = RUN;
            end else if (single_mode && step_press) begin
               state_d = STEP;
               rem_d   = burst_ld;
            end
         end
         RUN: begin
            if (eff_match) begin
               state_d = BP;
            end else if (run_press || single_mode) begin
               state_d = HALT;
            end
         end
         STEP: begin
            if (eff_match) begin
               state_d = BP;
            end else if (run_press || rem_q == 8'd1) begin
               state_d = HALT;
            end else begin
               rem_d = rem_q - 8'd1;
            end
         end
         BP: begin
            if (run_press) begin
               state_d = RUN;
               skip_d  = 1'b1;
            end else if (step_press) begin
               state_d = STEP;
               rem_d   = burst_ld;
               skip_d  = 1'b1;
            end
         end
      endcase
   end

   // State, burst counter, skip flag and executed-cycle counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HALT;
         rem_q   <= '0;
         skip_q  <= 1'b0;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         skip_q  <= skip_d;
         icnt_q  <= icnt_q + {15'd0, cpu_en};
      end
   end

   assign halted    = (state_q == HALT) | (state_q == BP);
   assign bp_hit    = (state_q == BP);
   assign state     = state_q;
   assign instr_cnt = icnt_q;

endmodule

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 SHALL provide parameter DB_COUNT, default 50000, consecutive stable cycles a synchronized button level must hold before the debounced level changes.
REQ-002 SHALL provide parameter PC_WIDTH, default 32, width of the pc and bp_addr ports.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_step  in  1  raw, unsynchronized step push-button.
REQ-006 SHALL have port btn_run  in  1  raw, unsynchronized run/stop push-button.
REQ-007 SHALL have port single_mode  in  1  board switch; 1 = single-step mode, 0 = free-run mode.
REQ-008 SHALL have port burst_len  in  8  number of CPU-enable cycles per step press; 0 is treated as 1.
REQ-009 SHALL have port bp_en  in  1  breakpoint enable.
REQ-010 SHALL have port bp_addr  in  PC_WIDTH  breakpoint address.
REQ-011 SHALL have port pc  in  PC_WIDTH  current CPU program counter.
REQ-012 SHALL have port cpu_en  out  1  CPU clock enable; the CPU advances one instruction per cycle it is high.
REQ-013 SHALL have port halted  out  1  high in HALT and BP states.
REQ-014 SHALL have port bp_hit  out  1  high only in BP state.
REQ-015 SHALL have port state  out  2  current state encoding.
REQ-016 SHALL have port instr_cnt  out  16  count of cycles with cpu_en high since reset.

Function
REQ-017 SHALL pass each button through a 2-flop synchronizer, then a debouncer that updates its level only after DB_COUNT consecutive equal samples.
REQ-018 SHALL generate run_press and step_press as one-cycle pulses on each rising edge of the respective debounced level; holding a button produces exactly one pulse.
REQ-019 SHALL implement states HALT=2'b00, RUN=2'b01, STEP=2'b10, BP=2'b11.
REQ-020 SHALL define match = bp_en and (pc == bp_addr), and eff_match = match and not skip, where skip is a 1-bit register.
REQ-021 SHALL drive cpu_en combinationally = (state is RUN or STEP) and not eff_match.
REQ-022 HALT: run_press with single_mode=0 -> RUN; step_press with single_mode=1 -> STEP, loading remaining = max(burst_len,1); otherwise stay.
REQ-023 RUN: eff_match -> BP; else run_press -> HALT; else single_mode=1 -> HALT; else stay. Precedence follows this order.
REQ-024 STEP: eff_match -> BP with remaining held; else if remaining==1 -> HALT after this enabled cycle; else decrement remaining; run_press -> HALT (abort, takes precedence over decrement); step_press and single_mode changes are ignored.
REQ-025 BP: run_press -> RUN; else step_press -> STEP, loading remaining = max(burst_len,1); on either exit set skip=1; otherwise stay.
REQ-026 skip SHALL clear after the first cycle spent in RUN or STEP, so an instruction sitting on the breakpoint executes once before matching resumes.
REQ-027 instr_cnt SHALL increment on every cycle cpu_en=1 and wrap from 16'hFFFF to 0.
REQ-028 run_press and step_press in the same cycle: run_press wins in BP; in HALT, single_mode selects which one is honored.
REQ-029 halted, bp_hit and state SHALL be decoded from the state register only (glitch-free).

Reset
REQ-030 On rst low, SHALL asynchronously set state=HALT, remaining=0, skip=0, instr_cnt=0, debounced levels=0 and synchronizer/debounce counters=0; hence cpu_en=0, halted=1, bp_hit=0.
REQ-031 Reset asserted mid-RUN or mid-STEP SHALL force cpu_en=0 immediately, without waiting for a clock edge; after release, no press pulse is generated from a button already held down until it is released and pressed again.

Verification (bench uses DB_COUNT=4)
REQ-032 Single step: single_mode=1, burst_len=0, step pressed 10 cycles -> exactly one cpu_en cycle, instr_cnt=1, back to HALT.
REQ-033 Burst: single_mode=1, burst_len=5, step pressed -> cpu_en high for 5 consecutive cycles, instr_cnt=5, state returns to 2'b00.
REQ-034 Breakpoint: single_mode=0, bp_en=1, bp_addr=0x40, run pressed, pc increments by 4 from 0 -> cpu_en drops in the cycle pc=0x40, state=2'b11, bp_hit=1; run pressed again -> one cycle with pc=0x40 enabled, RUN continues.
REQ-035 Bounce: btn_step toggles every 2 cycles for 20 cycles, then held high -> exactly one step_press pulse, one STEP entry.
REQ-036 Abort and reset: burst_len=200 in STEP, run pressed after 50 enables -> HALT, instr_cnt=50 plus the debounce delay; rst low while in RUN -> cpu_en=0 and instr_cnt=0 with no clock edge.
